// File: rtl/pn_sequence_checker.sv
// PN-8 (b[n] = b[n-8] ^ b[n-6]) sequence checker with search/verify/lock and flywheel.
// Define PN_CHECKER_ERR_CNT_EN to build the saturating error counter on err_cnt_o.
module pn_sequence_checker #(
  parameter int LOCK_THRESH = 16,
  parameter int LOSS_THRESH = 4,
  parameter int WINDOW_LEN  = 32
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  input  logic        pn_bit_i,
  input  logic        clear_i,
  output logic        lock_o,
  output logic        err_o,
  output logic [15:0] err_cnt_o
);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  localparam logic [7:0] LOCK_LAST = 8'(LOCK_THRESH - 1);
  localparam logic [7:0] LOSS_LAST = 8'(LOSS_THRESH - 1);
  localparam logic [7:0] WIN_LAST  = 8'(WINDOW_LEN - 1);

  state_t      state_reg, state_next;
  logic [7:0]  hist_reg, hist_next;
  logic [3:0]  fill_reg, fill_next;
  logic [7:0]  match_reg, match_next;
  logic [7:0]  win_bit_reg, win_bit_next;
  logic [7:0]  win_err_reg, win_err_next;
  logic        lock_reg;
  logic        err_reg, err_next;
  logic        predicted;
  logic        bit_err;

  assign predicted = hist_reg[7] ^ hist_reg[5];
  assign bit_err   = pn_bit_i ^ predicted;

  always_comb begin
    state_next   = state_reg;
    hist_next    = hist_reg;
    fill_next    = fill_reg;
    match_next   = match_reg;
    win_bit_next = win_bit_reg;
    win_err_next = win_err_reg;
    err_next     = 1'b0;
    if (valid_i) begin
      case (state_reg)
        SEARCH: begin
          hist_next = {hist_reg[6:0], pn_bit_i};
          if (fill_reg == 4'd7) begin
            fill_next  = 4'd0;
            match_next = 8'd0;
            state_next = VERIFY;
          end else begin
            fill_next = fill_reg + 4'd1;
          end
        end
        VERIFY: begin
          hist_next = {hist_reg[6:0], pn_bit_i};
          // An all-zero history predicts zeros forever, so it must never qualify.
          if (bit_err || (hist_reg == 8'h00)) begin
            match_next = 8'd0;
          end else if (match_reg == LOCK_LAST) begin
            match_next   = 8'd0;
            win_bit_next = 8'd0;
            win_err_next = 8'd0;
            state_next   = LOCKED;
          end else begin
            match_next = match_reg + 8'd1;
          end
        end
        LOCKED: begin
          hist_next = {hist_reg[6:0], predicted};
          err_next  = bit_err;
          // Loss is tested before the wrap so an error on the last window bit still counts.
          if (bit_err && (win_err_reg == LOSS_LAST)) begin
            state_next   = SEARCH;
            fill_next    = 4'd0;
            match_next   = 8'd0;
            win_bit_next = 8'd0;
            win_err_next = 8'd0;
          end else if (win_bit_reg == WIN_LAST) begin
            win_bit_next = 8'd0;
            win_err_next = 8'd0;
          end else begin
            win_bit_next = win_bit_reg + 8'd1;
            win_err_next = win_err_reg + {7'd0, bit_err};
          end
        end
        default: state_next = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg   <= SEARCH;
      hist_reg    <= 8'h00;
      fill_reg    <= 4'd0;
      match_reg   <= 8'd0;
      win_bit_reg <= 8'd0;
      win_err_reg <= 8'd0;
      lock_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      hist_reg    <= hist_next;
      fill_reg    <= fill_next;
      match_reg   <= match_next;
      win_bit_reg <= win_bit_next;
      win_err_reg <= win_err_next;
      lock_reg    <= (state_next == LOCKED);
      err_reg     <= err_next;
    end
  end

  assign lock_o = lock_reg;
  assign err_o  = err_reg;

`ifdef PN_CHECKER_ERR_CNT_EN
  logic [15:0] err_cnt_reg;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      err_cnt_reg <= 16'h0000;
    end else if (clear_i) begin
      err_cnt_reg <= 16'h0000;
    end else if (err_next && (err_cnt_reg != 16'hFFFF)) begin
      err_cnt_reg <= err_cnt_reg + 16'd1;
    end
  end

  assign err_cnt_o = err_cnt_reg;
`else
  logic unused_clear;
  assign unused_clear = clear_i;
  assign err_cnt_o    = 16'h0000;
`endif

endmodule

// File: doc/pn_sequence_checker.md
PN_SEQUENCE_CHECKER -- requirements
Module: pn_sequence_checker

Interface
REQ-001 Parameter LOCK_THRESH, default 16: consecutive matching bits required to declare lock (range 1..255).
REQ-002 Parameter LOSS_THRESH, default 4: errors within one monitor window that force loss of lock (range 1..WINDOW_LEN).
REQ-003 Parameter WINDOW_LEN, default 32: valid bits per monitor window while locked (range 2..255).
REQ-004 clk_i  input  1  clock; all state updates on its rising edge.
REQ-005 reset_i  input  1  asynchronous, active-high reset.
REQ-006 valid_i  input  1  qualifies pn_bit_i; one received bit per cycle with valid_i=1.
REQ-007 pn_bit_i  input  1  received PN bit stream.
REQ-008 clear_i  input  1  synchronous clear of err_cnt_o.
REQ-009 lock_o  output  1  registered; high while in LOCKED.
REQ-010 err_o  output  1  registered one-cycle pulse per bit error detected in LOCKED.
REQ-011 err_cnt_o  output  16  registered saturating count of errors detected in LOCKED.

Function
REQ-012 The block SHALL check the recurrence b[n] = b[n-8] XOR b[n-6] (8-bit LFSR, taps 7 and 5, MSB output).
REQ-013 An 8-bit history register hist SHALL hold previous bits, hist[0] newest; predicted bit = hist[7] XOR hist[5]; a shift moves hist left, inserting the new bit at hist[0].
REQ-014 Cycles with valid_i=0 SHALL change no state and produce err_o=0.
REQ-015 States: SEARCH, VERIFY, LOCKED; reset state SEARCH.
REQ-016 SEARCH: each valid bit shifts into hist and increments a fill counter; on the 8th valid bit the block SHALL go to VERIFY with match count 0.
REQ-017 VERIFY: each valid bit SHALL shift the received bit into hist; a match increments the match count, a mismatch resets it to 0.
REQ-018 VERIFY: a history of all zeros SHALL count as a mismatch, so an all-zero stream never locks.
REQ-019 VERIFY: the valid bit that brings the match count to LOCK_THRESH SHALL move to LOCKED; lock_o rises the following cycle.
REQ-020 LOCKED: hist SHALL shift in the predicted bit (flywheel), not the received bit.
REQ-021 LOCKED: a received bit differing from the predicted bit SHALL pulse err_o the next cycle and increment the window error count.
REQ-022 LOCKED: the window bit count SHALL wrap after WINDOW_LEN valid bits, clearing the window error count on the same edge.
REQ-023 LOCKED: when the window error count reaches LOSS_THRESH, the block SHALL go to SEARCH, clear fill/match/window counters, and deassert lock_o the next cycle.
REQ-024 An error on the window's final bit SHALL be counted before the wrap, so reaching LOSS_THRESH on that bit still causes loss of lock.
REQ-025 err_cnt_o SHALL saturate at 0xFFFF.
REQ-026 If clear_i and an error occur in the same cycle, err_cnt_o SHALL become 0; clear wins.
REQ-027 Bits in SEARCH and VERIFY SHALL never assert err_o or change err_cnt_o.

Reset
REQ-028 reset_i SHALL asynchronously force state SEARCH, hist=0x00, all internal counters 0, lock_o=0, err_o=0, err_cnt_o=0.
REQ-029 Reset asserted mid-operation, including in LOCKED, SHALL discard the lock; re-lock requires 8 fill bits plus LOCK_THRESH matches.

Configuration
REQ-030 With macro PN_CHECKER_ERR_CNT_EN defined, err_cnt_o SHALL behave as in REQ-011, REQ-025 and REQ-026.
REQ-031 Without PN_CHECKER_ERR_CNT_EN, err_cnt_o SHALL be constant 0, the counter SHALL be absent, and clear_i SHALL be ignored; err_o and lock behaviour are unchanged.

Verification
REQ-032 Generator stream seeded 0xFF (bits 1,1,1,1,1,1,1,1,0,...), valid_i=1 continuously -> lock_o rises one cycle after the 24th valid bit; err_o stays 0.
REQ-033 While locked, invert one bit -> exactly one err_o pulse and err_cnt_o=1; lock_o stays high; no further errors (flywheel).
REQ-034 While locked, invert 4 bits within one 32-bit window -> lock_o falls the cycle after the 4th error; invert 3 bits per window indefinitely -> lock_o stays high.
REQ-035 All-zero stream for 100 valid bits -> lock_o never asserts and err_cnt_o stays 0.
REQ-036 Preload err_cnt_o to 0xFFFF via errors, then inject 1 error -> count stays 0xFFFF; clear_i in the same cycle as an error -> 0.
REQ-037 Assert reset_i asynchronously while locked, with valid_i gapped randomly -> outputs 0 immediately; re-lock after 8+16 valid bits.
